// File: rtl/lut_sweep_reader.sv
// Sweeps every input code of one neuron LUT and streams (addr, data)
// records, accumulating a per-code histogram and a rotate-XOR signature.
module lut_sweep_reader #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 2,
   parameter int LUT_LAT  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic [IN_BITS-1:0]  lut_addr,
   input  logic [OUT_BITS-1:0] lut_data,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [IN_BITS-1:0]  rec_addr,
   output logic [OUT_BITS-1:0] rec_data,
   output logic [15:0]         sig,
   output logic [(2**OUT_BITS)*(IN_BITS+1)-1:0] hist
);

   localparam int NC = 2**OUT_BITS;
   localparam int CW = IN_BITS + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_PRESENT,
      S_FINISH
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [1:0]          r_wait;
   logic [IN_BITS-1:0]  r_lut_addr;
   logic                r_rec_valid;
   logic [IN_BITS-1:0]  r_rec_addr;
   logic [OUT_BITS-1:0] r_rec_data;
   logic [15:0]         r_sig;
   logic [CW-1:0]       r_hist [NC];

   logic w_last;
   logic w_go;
   logic w_cap;
   logic w_acc;
   logic w_busy;

   assign w_busy = (r_state == S_SETTLE) || (r_state == S_PRESENT);
   assign w_last = (r_lut_addr == {IN_BITS{1'b1}});
   assign w_go   = (r_state == S_IDLE) && start;
   assign w_cap  = (r_state == S_SETTLE) && (r_wait == 2'd0) && !abort;
   assign w_acc  = (r_state == S_PRESENT) && rec_ready && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (abort) w_next = S_IDLE;
            else if (r_wait == 2'd0) w_next = S_PRESENT;
         end
         S_PRESENT: begin
            if (abort) w_next = S_IDLE;
            else if (rec_ready) w_next = w_last ? S_FINISH : S_SETTLE;
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait      <= '0;
         r_lut_addr  <= '0;
         r_rec_valid <= 1'b0;
         r_rec_addr  <= '0;
         r_rec_data  <= '0;
         r_sig       <= '0;
         for (int c = 0; c < NC; c++) r_hist[c] <= '0;
      end else begin
         if (w_go) begin
            r_lut_addr <= '0;
            r_wait     <= 2'(LUT_LAT);
            r_sig      <= '0;
            for (int c = 0; c < NC; c++) r_hist[c] <= '0;
         end
         if ((r_state == S_SETTLE) && !abort && (r_wait != 2'd0))
            r_wait <= r_wait - 2'd1;
         if (w_cap) begin
            r_rec_addr       <= r_lut_addr;
            r_rec_data       <= lut_data;
            r_rec_valid      <= 1'b1;
            r_hist[lut_data] <= r_hist[lut_data] + CW'(1);
            r_sig            <= {r_sig[14:0], r_sig[15]} ^ 16'(lut_data);
         end
         if (w_acc) begin
            r_rec_valid <= 1'b0;
            if (!w_last) begin
               r_lut_addr <= r_lut_addr + IN_BITS'(1);
               r_wait     <= 2'(LUT_LAT);
            end
         end
         // abort wins over a same-cycle handshake or capture
         if (abort && w_busy) r_rec_valid <= 1'b0;
      end
   end

   for (genvar c = 0; c < NC; c++) begin : g_hist
      assign hist[c*CW +: CW] = r_hist[c];
   end

   assign busy      = w_busy;
   assign done      = (r_state == S_FINISH);
   assign lut_addr  = r_lut_addr;
   assign rec_valid = r_rec_valid;
   assign rec_addr  = r_rec_addr;
   assign rec_data  = r_rec_data;
   assign sig       = r_sig;

endmodule

// File: tb/tb_lut_sweep_reader.sv
// Bench for lut_sweep_reader: a combinational-LUT instance and a
// two-register LUT instance, checked against a per-sweep reference model.
module tb_lut_sweep_reader;

   localparam int IB = 6;
   localparam int OB = 2;
   localparam int CW = IB + 1;
   localparam int HW = 4 * CW;
   localparam int N  = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic sel = 1'b0;
   int   mode = 0;
   logic t_start = 1'b0;
   logic t_abort = 1'b0;
   logic ready = 1'b0;
   logic [OB-1:0] tab [N];

   int errs = 0;
   int chks = 0;

   logic          busy0, done0, valid0, busy1, done1, valid1;
   logic [IB-1:0] addr0, raddr0, addr1, raddr1;
   logic [OB-1:0] data0, rdata0, data1, rdata1;
   logic [15:0]   sig0, sig1;
   logic [HW-1:0] hist0, hist1;
   logic          s0, s1, a0, a1;
   logic [OB-1:0] p1, p2;

   function automatic logic [OB-1:0] lut_f(input int m, input int a);
      logic [IB-1:0] aa;
      aa = IB'(a);
      case (m)
         0:       return 2'b00;
         1:       return aa[1:0];
         2:       return 2'b01;
         default: return tab[aa];
      endcase
   endfunction

   assign data0 = lut_f(mode, int'(addr0));
   always @(posedge clk) begin
      p1 <= lut_f(mode, int'(addr1));
      p2 <= p1;
   end
   assign data1 = p2;

   assign s0 = t_start & ~sel;
   assign s1 = t_start & sel;
   assign a0 = t_abort & ~sel;
   assign a1 = t_abort & sel;

   lut_sweep_reader #(.IN_BITS(IB), .OUT_BITS(OB), .LUT_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(s0), .abort(a0),
      .busy(busy0), .done(done0), .lut_addr(addr0), .lut_data(data0),
      .rec_valid(valid0), .rec_ready(ready), .rec_addr(raddr0),
      .rec_data(rdata0), .sig(sig0), .hist(hist0)
   );

   lut_sweep_reader #(.IN_BITS(IB), .OUT_BITS(OB), .LUT_LAT(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .abort(a1),
      .busy(busy1), .done(done1), .lut_addr(addr1), .lut_data(data1),
      .rec_valid(valid1), .rec_ready(ready), .rec_addr(raddr1),
      .rec_data(rdata1), .sig(sig1), .hist(hist1)
   );

   logic          v_busy, v_done, v_valid;
   logic [IB-1:0] v_raddr;
   logic [OB-1:0] v_rdata;
   logic [15:0]   v_sig;
   logic [HW-1:0] v_hist;
   assign v_busy  = sel ? busy1 : busy0;
   assign v_done  = sel ? done1 : done0;
   assign v_valid = sel ? valid1 : valid0;
   assign v_raddr = sel ? raddr1 : raddr0;
   assign v_rdata = sel ? rdata1 : rdata0;
   assign v_sig   = sel ? sig1 : sig0;
   assign v_hist  = sel ? hist1 : hist0;

   task automatic chk(input string nm, input longint act, input longint exp);
      chks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int hsl(input logic [HW-1:0] h, input int c);
      logic [HW-1:0] t;
      t = h >> (c * CW);
      return int'(t[CW-1:0]);
   endfunction

   typedef struct {
      int sel;
      int mode;
      int rdy;
      int poke;
      int base;
   } tv_t;

   task automatic model_check(input int m, input int cnt);
      int mh[4];
      logic [15:0] ms;
      logic [OB-1:0] d;
      ms = '0;
      for (int c = 0; c < 4; c++) mh[c] = 0;
      for (int a = 0; a < cnt; a++) begin
         d = lut_f(m, a);
         mh[d]++;
         ms = {ms[14:0], ms[15]} ^ 16'(d);
      end
      chk("sig", v_sig, ms);
      for (int c = 0; c < 4; c++) chk($sformatf("hist%0d", c), hsl(v_hist, c), mh[c]);
   endtask

   task automatic kick();
      @(negedge clk);
      t_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_start = 1'b0;
   endtask

   task automatic sweep(input tv_t t);
      int k = 0;
      int stalls = 0;
      int c = 0;
      bit fin = 0;
      bit pv = 0;
      logic [IB-1:0] pa;
      logic [OB-1:0] pd;
      sel = t.sel[0];
      mode = t.mode;
      kick();
      chk("busy_rise", v_busy, 1);
      while (!fin && c < 4000) begin
         t_start = (c == t.poke);
         if (v_done) begin
            fin = 1;
            chk("done_edge", c, t.base + stalls);
         end else begin
            ready = ($urandom_range(99) < t.rdy);
            if (pv) begin
               chk("hold_valid", v_valid, 1);
               chk("hold_addr", v_raddr, pa);
               chk("hold_data", v_rdata, pd);
            end
            pv = 0;
            if (v_valid && ready) begin
               chk("rec_addr", v_raddr, k);
               chk("rec_data", v_rdata, lut_f(t.mode, k));
               k++;
            end else if (v_valid) begin
               stalls++;
               pv = 1;
               pa = v_raddr;
               pd = v_rdata;
            end
         end
         @(negedge clk);
         c++;
      end
      t_start = 1'b0;
      if (!fin) chk("done_timeout", 0, 1);
      chk("rec_count", k, N);
      chk("idle_after", v_busy, 0);
      model_check(t.mode, N);
   endtask

   tv_t tv[6];

   initial begin
      int c;
      int dn;
      bit hit;
      tv[0] = '{0, 0, 100, -1, 128};
      tv[1] = '{0, 1, 100, -1, 128};
      tv[2] = '{0, 2, 100, -1, 128};
      tv[3] = '{1, 3, 50, 40, 256};
      tv[4] = '{1, 3, 100, -1, 256};
      tv[5] = '{0, 3, 60, 70, 128};
      for (int a = 0; a < N; a++) tab[a] = OB'($urandom);

      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy0 | busy1, 0);
      chk("rst_done", done0 | done1, 0);
      chk("rst_valid", valid0 | valid1, 0);
      chk("rst_addr", addr0 | addr1, 0);
      chk("rst_sig", sig0 | sig1, 0);
      chk("rst_hist", hist0 | hist1, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) sweep(tv[i]);

      // abort while address 10 is presented
      sel = 1'b0;
      mode = 1;
      ready = 1'b1;
      kick();
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (v_valid && v_raddr == 6'd10) hit = 1;
         else @(negedge clk);
      end
      if (!hit) chk("abort_reach", 0, 1);
      t_abort = 1'b1;
      @(negedge clk);
      t_abort = 1'b0;
      chk("abort_busy", v_busy, 0);
      chk("abort_valid", v_valid, 0);
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         if (v_done) dn++;
         @(negedge clk);
      end
      chk("abort_nodone", dn, 0);
      c = 0;
      for (int i = 0; i < 4; i++) c += hsl(v_hist, i);
      chk("abort_total", c, 11);
      model_check(1, 11);
      sweep(tv[1]);

      // reset during SETTLE of address 30
      sel = 1'b0;
      mode = 3;
      ready = 1'b1;
      kick();
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (busy0 && !valid0 && addr0 == 6'd30) hit = 1;
         else @(negedge clk);
      end
      if (!hit) chk("rst_reach", 0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_busy", busy0, 0);
      chk("mid_done", done0, 0);
      chk("mid_valid", valid0, 0);
      chk("mid_addr", addr0, 0);
      chk("mid_raddr", raddr0, 0);
      chk("mid_rdata", rdata0, 0);
      chk("mid_sig", sig0, 0);
      chk("mid_hist", hist0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep(tv[0]);

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
